dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Parametrised data-memory bridge between the CPU data port and a word-wide synchronous-read RAM. Performs base-address translation, range and alignment checking, and byte/halfword lane steering with sign or zero extension. Sub-word stores are done as read-modify-write, or in one cycle with byte strobes when configured. Sits in the computer top level where the CPU data port previously connected straight to DMEM through a fixed address subtraction.

## Interface
- `BASE_ADDR`, 32'h10010000: CPU byte address mapped to RAM word 0.
- `DEPTH_WORDS`, 2048: RAM depth in 32-bit words; power of two, at least 2.
- `AW`, $clog2(DEPTH_WORDS): RAM word-address width (derived, do not override).

Ports:
- `clk_in` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `dmem_r` in 1: load request.
- `dmem_w` in 1: store request.
- `dmem_width` in 2: access width. 00 = word, 01 = half, 10 = byte, 11 = illegal.
- `dmem_signed` in 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `dmem_addr` in 32: CPU byte address.
- `dmem_wdata` in 32: store data, right-aligned.
- `dmem_rdata` out 32: load result, extended; holds its value until the next load completes.
- `dmem_stall` out 1: CPU must hold its request stable and not advance.
- `dmem_fault` out 1: one-cycle pulse when a request is rejected.
- `fault_addr` out 32: address of the most recent rejected request.
- `ram_addr` out AW: RAM word address.
- `ram_re` out 1: RAM read enable; data is returned on the next cycle.
- `ram_we` out 1: RAM write enable.
- `ram_wdata` out 32: RAM write word.
- `ram_rdata` in 32: RAM read word.
- `ram_be` out 4: byte write enables. Present only when `DMEM_BYTE_STROBE_EN` is defined.

## Operation
- Offset = `dmem_addr` − `BASE_ADDR`, computed modulo 2^32.
  - In range when offset < DEPTH_WORDS*4.
  - Word address = offset[AW+1:2].
  - Lanes are little-endian: byte k is at bits [8k+7:8k].
- A request is rejected, with no RAM access, no stall, `dmem_fault`=1 for one cycle and `fault_addr` loaded, on any of:
  - out of range;
  - width 11;
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - `dmem_r` and `dmem_w` both high.
- State machine states: IDLE, LOAD_WAIT, RMW_WRITE.
  - IDLE, valid load: `ram_re`=1, `dmem_stall`=1, capture addr[1:0], width and signed → LOAD_WAIT.
  - IDLE, valid word store: `ram_we`=1, no stall, stay in IDLE.
  - IDLE, valid sub-word store, RMW build: `ram_re`=1, `dmem_stall`=1, capture address, width and wdata → RMW_WRITE.
  - LOAD_WAIT: select lane from `ram_rdata`, extend, register into `dmem_rdata`; `dmem_stall`=0 → IDLE.
  - RMW_WRITE: replace the captured lane(s) of `ram_rdata` with the low bits of wdata; `ram_we`=1, `dmem_stall`=0 → IDLE.
- Requests are only evaluated in IDLE. In other states, request inputs are ignored apart from being held by the CPU.
- Reset values:
  - state IDLE;
  - `dmem_rdata`=0, `fault_addr`=0;
  - `dmem_fault`=0, `dmem_stall`=0, `ram_re`=0, `ram_we`=0;
  - `ram_addr`=0, `ram_wdata`=0, `ram_be`=0.
- Reset asserted mid-operation aborts the operation: no write is issued and RMW state is discarded.

## Timing
- `dmem_stall`, `ram_re`, `ram_we`, `ram_addr`, `ram_wdata` and `ram_be` are combinational from the state register and the inputs.
- `dmem_rdata`, `fault_addr` and `dmem_fault` are registered.
  - `dmem_fault` is high in the cycle after the rejected request.
- Latencies:
  - Load: 1 stall cycle. `dmem_rdata` is valid from the edge that ends LOAD_WAIT.
  - Word store: 0 stall cycles.
  - Sub-word store, RMW build: 1 stall cycle.
- Back-to-back requests are accepted on the cycle immediately after the stall drops.

## Configuration
- `DMEM_BYTE_STROBE_EN` defined:
  - `ram_be` port exists.
  - Sub-word stores complete in IDLE in a single cycle: `ram_we`=1, `ram_be` is the lane mask, `ram_wdata` is the data replicated across lanes, no stall.
  - The RMW_WRITE state is not built.
  - Word stores drive `ram_be`=4'hF.
- Undefined: no `ram_be` port; the RMW path above is used.

## Structure
- Shared package `dmem_pkg`:
  - width encodings `W_WORD`/`W_HALF`/`W_BYTE`;
  - state enum `dmem_state_t`;
  - default `BASE_ADDR` constant.
- One natural sub-module, `dmem_lane`: purely combinational.
  - Load extract and extend: rdata, offset, width, signed → 32-bit result.
  - Store merge: old word, new data, offset, width → merged word and lane mask.

## Test plan
- Word store then load:
  - Stimulus: store 0xDEADBEEF at 0x10010004, then load word.
  - Required: `ram_addr`=1; `dmem_rdata`=0xDEADBEEF after exactly 1 stall cycle.
- Byte loads:
  - Stimulus: RAM word 1 = 0xDEADBEEF; load byte at 0x10010007, first with signed=1, then with signed=0.
  - Required: 0xFFFFFFDE, then 0x000000DE.
- Halfword store (RMW build):
  - Stimulus: store half 0x1234 at 0x10010006 over 0xDEADBEEF.
  - Required: 1 stall cycle; RAM word = 0x1234BEEF.
  - With `DMEM_BYTE_STROBE_EN`: `ram_be`=4'b1100 and no stall.
- Rejected requests:
  - Stimulus: word load at 0x10010002; then word store at 0x10012000 with DEPTH_WORDS=2048.
  - Required: each gives a `dmem_fault` pulse; `fault_addr` = 0x10010002, then 0x10012000; `ram_we` never asserted.
- Reset mid-operation:
  - Stimulus: reset asserted during RMW read cycle of a byte store.
  - Required: RAM word unchanged; all outputs at reset values; state IDLE.
- Back-to-back:
  - Stimulus: load then store on consecutive accepted cycles.
  - Required: no lost or duplicated RAM access; store issued the cycle after LOAD_WAIT.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory bridge.
//   - access width encodings driven by the CPU on dmem_width
//   - bridge state enum
//   - default CPU byte address of RAM word 0
//   - lane replication helper used by the byte-strobe store path
package dmem_pkg;

   localparam logic [1:0] W_WORD    = 2'b00;
   localparam logic [1:0] W_HALF    = 2'b01;
   localparam logic [1:0] W_BYTE    = 2'b10;
   localparam logic [1:0] W_ILLEGAL = 2'b11;

   localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      RMW_WRITE = 2'd2
   } dmem_state_t;

   // Copies the low byte/halfword of d into every lane of the word.
   function automatic logic [31:0] lane_replicate(input logic [31:0] d, input logic [1:0] w);
      case (w)
         W_BYTE:  lane_replicate = {4{d[7:0]}};
         W_HALF:  lane_replicate = {2{d[15:0]}};
         default: lane_replicate = d;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: combinational byte/halfword lane steering.
//   Load side : ld_word, ld_off, ld_width, ld_signed -> ld_result (extended)
//   Store side: st_old, st_data, st_off, st_width    -> st_merged, st_mask
// Lanes are little-endian (byte k at bits [8k+7:8k]). Any width other than
// byte/half is treated as a full word.
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [31:0] ld_word,
   input  logic [1:0]  ld_off,
   input  logic [1:0]  ld_width,
   input  logic        ld_signed,
   output logic [31:0] ld_result,
   input  logic [31:0] st_old,
   input  logic [31:0] st_data,
   input  logic [1:0]  st_off,
   input  logic [1:0]  st_width,
   output logic [31:0] st_merged,
   output logic [3:0]  st_mask
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      ld_byte = ld_word[{ld_off, 3'b000} +: 8];
      ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
      case (ld_width)
         W_BYTE:  ld_result = {{24{ld_signed & ld_byte[7]}}, ld_byte};
         W_HALF:  ld_result = {{16{ld_signed & ld_half[15]}}, ld_half};
         default: ld_result = ld_word;
      endcase
   end

   always_comb begin
      st_merged = st_old;
      st_mask   = 4'hF;
      case (st_width)
         W_BYTE: begin
            st_mask = 4'b0001 << st_off;
            st_merged[{st_off, 3'b000} +: 8] = st_data[7:0];
         end
         W_HALF: begin
            st_mask = st_off[1] ? 4'b1100 : 4'b0011;
            st_merged[{st_off[1], 4'b0000} +: 16] = st_data[15:0];
         end
         default: st_merged = st_data;
      endcase
   end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: CPU data port to word-wide synchronous-read RAM bridge.
//   Base-address translation, range/alignment checking, lane steering with
//   sign/zero extension, sub-word stores by read-modify-write.
// Optional build macro: DMEM_BYTE_STROBE_EN
//   defined   -> ram_be port exists, sub-word stores finish in one cycle
//                using byte strobes and replicated write data.
//   undefined -> no ram_be port, sub-word stores go through RMW_WRITE.
// Ports:
//   clk_in, rst (async, active low)
//   CPU side : dmem_r, dmem_w, dmem_width, dmem_signed, dmem_addr, dmem_wdata
//              -> dmem_rdata, dmem_stall, dmem_fault, fault_addr
//   RAM side : ram_addr, ram_re, ram_we, ram_wdata, [ram_be] <- ram_rdata
//
// state     | meaning
// IDLE      | evaluating CPU requests; word stores complete here
// LOAD_WAIT | RAM read data arriving, extracted lane registered to dmem_rdata
// RMW_WRITE | old word arriving, merged with captured store data and written
module dmem_bridge
   import dmem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
   parameter int          DEPTH_WORDS = 2048,
   parameter int          AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk_in,
   input  logic          rst,
   input  logic          dmem_r,
   input  logic          dmem_w,
   input  logic [1:0]    dmem_width,
   input  logic          dmem_signed,
   input  logic [31:0]   dmem_addr,
   input  logic [31:0]   dmem_wdata,
   output logic [31:0]   dmem_rdata,
   output logic          dmem_stall,
   output logic          dmem_fault,
   output logic [31:0]   fault_addr,
   output logic [AW-1:0] ram_addr,
   output logic          ram_re,
   output logic          ram_we,
   output logic [31:0]   ram_wdata,
`ifdef DMEM_BYTE_STROBE_EN
   output logic [3:0]    ram_be,
`endif
   input  logic [31:0]   ram_rdata
);

   localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

   dmem_state_t   state, state_nxt;
   logic [31:0]   offset;
   logic [AW-1:0] req_word;
   logic          in_range, misaligned;
   logic          req, req_bad, req_ok;

   logic [1:0]    cap_off, cap_width;
   logic          cap_signed;
`ifndef DMEM_BYTE_STROBE_EN
   logic [AW-1:0] cap_addr;
   logic [31:0]   cap_wdata;
`endif

   logic [31:0]   ld_result, st_old, st_data, st_merged;
   logic [1:0]    st_off, st_width;
   logic [3:0]    st_mask;

   // Offset wraps modulo 2^32, so addresses below the base land far out of range.
   assign offset     = dmem_addr - BASE_ADDR;
   assign req_word   = offset[AW+1:2];
   assign in_range   = {1'b0, offset} < SPAN_BYTES;
   assign misaligned = ((dmem_width == W_HALF) && dmem_addr[0]) ||
                       ((dmem_width == W_WORD) && (dmem_addr[1:0] != 2'b00));
   // rst is folded in so that nothing reaches the RAM while reset is held.
   assign req        = rst && (state == IDLE) && (dmem_r || dmem_w);
   assign req_bad    = !in_range || (dmem_width == W_ILLEGAL) || misaligned ||
                       (dmem_r && dmem_w);
   assign req_ok     = req && !req_bad;

`ifdef DMEM_BYTE_STROBE_EN
   // With the old word set to the replicated data, the merge result is the
   // replicated data itself, and st_mask gives the byte strobes.
   assign st_old   = lane_replicate(dmem_wdata, dmem_width);
   assign st_data  = dmem_wdata;
   assign st_off   = dmem_addr[1:0];
   assign st_width = dmem_width;
`else
   // IDLE sees the live request (to classify word vs sub-word); RMW_WRITE
   // merges the captured store into the word the RAM just returned.
   assign st_old   = ram_rdata;
   assign st_data  = (state == IDLE) ? dmem_wdata     : cap_wdata;
   assign st_off   = (state == IDLE) ? dmem_addr[1:0] : cap_off;
   assign st_width = (state == IDLE) ? dmem_width     : cap_width;
`endif

   dmem_lane u_lane (
      .ld_word   (ram_rdata),
      .ld_off    (cap_off),
      .ld_width  (cap_width),
      .ld_signed (cap_signed),
      .ld_result (ld_result),
      .st_old    (st_old),
      .st_data   (st_data),
      .st_off    (st_off),
      .st_width  (st_width),
      .st_merged (st_merged),
      .st_mask   (st_mask)
   );

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cap_off    <= '0;
         cap_width  <= '0;
         cap_signed <= 1'b0;
`ifndef DMEM_BYTE_STROBE_EN
         cap_addr   <= '0;
         cap_wdata  <= '0;
`endif
         dmem_rdata <= '0;
         fault_addr <= '0;
         dmem_fault <= 1'b0;
      end else begin
         state      <= state_nxt;
         dmem_fault <= req && req_bad;
         if (req && req_bad) begin
            fault_addr <= dmem_addr;
         end
         if (req_ok) begin
            cap_off    <= dmem_addr[1:0];
            cap_width  <= dmem_width;
            cap_signed <= dmem_signed;
`ifndef DMEM_BYTE_STROBE_EN
            cap_addr   <= req_word;
            cap_wdata  <= dmem_wdata;
`endif
         end
         if (state == LOAD_WAIT) begin
            dmem_rdata <= ld_result;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      dmem_stall = 1'b0;
      ram_re     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_wdata  = '0;
`ifdef DMEM_BYTE_STROBE_EN
      ram_be     = 4'h0;
`endif
      case (state)
         IDLE: begin
            if (req_ok && dmem_r) begin
               ram_re     = 1'b1;
               ram_addr   = req_word;
               dmem_stall = 1'b1;
               state_nxt  = LOAD_WAIT;
            end else if (req_ok) begin
`ifdef DMEM_BYTE_STROBE_EN
               ram_we    = 1'b1;
               ram_addr  = req_word;
               ram_wdata = st_merged;
               ram_be    = st_mask;
`else
               ram_addr = req_word;
               if (st_mask == 4'hF) begin
                  ram_we    = 1'b1;
                  ram_wdata = st_merged;
               end else begin
                  ram_re     = 1'b1;
                  dmem_stall = 1'b1;
                  state_nxt  = RMW_WRITE;
               end
`endif
            end
         end
         LOAD_WAIT: begin
            state_nxt = IDLE;
         end
`ifndef DMEM_BYTE_STROBE_EN
         RMW_WRITE: begin
            ram_we    = 1'b1;
            ram_addr  = cap_addr;
            ram_wdata = st_merged;
            state_nxt = IDLE;
         end
`endif
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed self-checking bench for dmem_bridge with a
// behavioural synchronous-read RAM attached. Handles either build of
// DMEM_BYTE_STROBE_EN.
module tb_dmem_bridge;
   import dmem_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst    = 1'b0;
   logic        dmem_r, dmem_w, dmem_signed;
   logic [1:0]  dmem_width;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [31:0] dmem_rdata, fault_addr;
   logic        dmem_stall, dmem_fault;
   logic [10:0] ram_addr;
   logic        ram_re, ram_we;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = 32'h0;
`ifdef DMEM_BYTE_STROBE_EN
   logic [3:0]  ram_be;
`endif

   int n_pass  = 0;
   int n_total = 0;
   int n_re    = 0;
   int n_we    = 0;

   logic [31:0] mem [0:2047];
   logic [31:0] saved;
   int          re0, we0;

   always #5 clk_in = ~clk_in;

   dmem_bridge #(.BASE_ADDR(32'h1001_0000), .DEPTH_WORDS(2048)) dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .dmem_r      (dmem_r),
      .dmem_w      (dmem_w),
      .dmem_width  (dmem_width),
      .dmem_signed (dmem_signed),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_rdata  (dmem_rdata),
      .dmem_stall  (dmem_stall),
      .dmem_fault  (dmem_fault),
      .fault_addr  (fault_addr),
      .ram_addr    (ram_addr),
      .ram_re      (ram_re),
      .ram_we      (ram_we),
      .ram_wdata   (ram_wdata),
`ifdef DMEM_BYTE_STROBE_EN
      .ram_be      (ram_be),
`endif
      .ram_rdata   (ram_rdata)
   );

   always @(posedge clk_in) begin
      if (ram_re) begin
         ram_rdata <= mem[ram_addr];
         n_re      <= n_re + 1;
      end
      if (ram_we) begin
`ifdef DMEM_BYTE_STROBE_EN
         for (int k = 0; k < 4; k++)
            if (ram_be[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
`else
         mem[ram_addr] <= ram_wdata;
`endif
         n_we <= n_we + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic drive(input logic r, input logic w, input logic [1:0] wd,
                        input logic s, input logic [31:0] a, input logic [31:0] d);
      dmem_r = r; dmem_w = w; dmem_width = wd; dmem_signed = s;
      dmem_addr = a; dmem_wdata = d;
   endtask

   task automatic drive_idle();
      drive(1'b0, 1'b0, W_WORD, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk_in); #1;
   endtask

   // Load: one stall cycle, result registered at the edge ending LOAD_WAIT.
   task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] wd,
                          input logic s, input logic [31:0] exp);
      drive(1'b1, 1'b0, wd, s, a, 32'h0); #1;
      chk({tag, "_stall"}, {31'h0, dmem_stall}, 32'h1);
      tick();
      chk({tag, "_wait_stall"}, {31'h0, dmem_stall}, 32'h0);
      tick();
      drive_idle();
      chk(tag, dmem_rdata, exp);
   endtask

   task automatic do_sub_store(input string tag, input logic [31:0] a, input logic [1:0] wd,
                               input logic [31:0] d, input logic [3:0] be_exp,
                               input logic [31:0] word_exp);
      drive(1'b0, 1'b1, wd, 1'b0, a, d); #1;
`ifdef DMEM_BYTE_STROBE_EN
      chk({tag, "_stall"}, {31'h0, dmem_stall}, 32'h0);
      chk({tag, "_we"}, {31'h0, ram_we}, 32'h1);
      chk({tag, "_be"}, {28'h0, ram_be}, {28'h0, be_exp});
      chk({tag, "_wdata"}, ram_wdata, lane_replicate(d, wd));
      tick();
`else
      chk({tag, "_stall"}, {31'h0, dmem_stall}, 32'h1);
      chk({tag, "_re_we"}, {30'h0, ram_re, ram_we}, 32'h2);
      tick();
      chk({tag, "_rmw_we"}, {31'h0, ram_we}, 32'h1);
      chk({tag, "_rmw_stall"}, {31'h0, dmem_stall}, 32'h0);
      chk({tag, "_rmw_wdata"}, ram_wdata, word_exp);
      tick();
      if (be_exp == 4'h0) chk({tag, "_be_arg"}, 32'h1, 32'h0);
`endif
      drive_idle();
      chk({tag, "_mem"}, mem[1], word_exp);
   endtask

   task automatic do_reject(input string tag, input logic r, input logic w,
                            input logic [1:0] wd, input logic [31:0] a);
      drive(r, w, wd, 1'b0, a, 32'hFFFF_FFFF); #1;
      chk({tag, "_no_access"}, {29'h0, ram_re, ram_we, dmem_stall}, 32'h0);
      tick();
      drive_idle();
      chk({tag, "_fault"}, {31'h0, dmem_fault}, 32'h1);
      chk({tag, "_faddr"}, fault_addr, a);
      tick();
      chk({tag, "_pulse"}, {31'h0, dmem_fault}, 32'h0);
   endtask

   initial begin
      drive_idle();
      repeat (2) @(posedge clk_in);
      #1;
      // A request presented while reset is held must not reach the RAM.
      drive(1'b0, 1'b1, W_WORD, 1'b0, 32'h1001_0000, 32'h1234_5678); #1;
      chk("rst_ram_ctl", {29'h0, ram_re, ram_we, dmem_stall}, 32'h0);
      chk("rst_ram_addr", {21'h0, ram_addr}, 32'h0);
      chk("rst_ram_wdata", ram_wdata, 32'h0);
      chk("rst_rdata", dmem_rdata, 32'h0);
      chk("rst_faddr", fault_addr, 32'h0);
      chk("rst_fault", {31'h0, dmem_fault}, 32'h0);
      drive_idle();
      rst = 1'b1;
      tick();

      // Word store, zero stall.
      drive(1'b0, 1'b1, W_WORD, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF); #1;
      chk("wst_stall", {31'h0, dmem_stall}, 32'h0);
      chk("wst_we", {31'h0, ram_we}, 32'h1);
      chk("wst_addr", {21'h0, ram_addr}, 32'h1);
      chk("wst_wdata", ram_wdata, 32'hDEAD_BEEF);
`ifdef DMEM_BYTE_STROBE_EN
      chk("wst_be", {28'h0, ram_be}, 32'hF);
`endif
      tick();
      drive_idle();
      chk("wst_mem", mem[1], 32'hDEAD_BEEF);

      do_load("ld_word", 32'h1001_0004, W_WORD, 1'b0, 32'hDEAD_BEEF);
      do_load("ld_byte_s", 32'h1001_0007, W_BYTE, 1'b1, 32'hFFFF_FFDE);
      do_load("ld_byte_u", 32'h1001_0007, W_BYTE, 1'b0, 32'h0000_00DE);
      do_load("ld_half_s", 32'h1001_0004, W_HALF, 1'b1, 32'hFFFF_BEEF);
      do_load("ld_byte1_s", 32'h1001_0005, W_BYTE, 1'b1, 32'hFFFF_FFBE);

      do_sub_store("st_half", 32'h1001_0006, W_HALF, 32'h0000_1234, 4'b1100, 32'h1234_BEEF);
      do_sub_store("st_byte", 32'h1001_0005, W_BYTE, 32'hFFFF_FFAB, 4'b0010, 32'h1234_ABEF);
      do_load("ld_half_u", 32'h1001_0006, W_HALF, 1'b0, 32'h0000_1234);

      do_reject("rej_misalign", 1'b1, 1'b0, W_WORD, 32'h1001_0002);
      do_reject("rej_range", 1'b0, 1'b1, W_WORD, 32'h1001_2000);
      do_reject("rej_half_odd", 1'b1, 1'b0, W_HALF, 32'h1001_0001);
      do_reject("rej_width", 1'b1, 1'b0, W_ILLEGAL, 32'h1001_0000);
      do_reject("rej_rw", 1'b1, 1'b1, W_BYTE, 32'h1001_0000);
      do_reject("rej_below", 1'b1, 1'b0, W_WORD, 32'h1000_FFFC);
      chk("rej_mem_intact", mem[1], 32'h1234_ABEF);

      // Last word in range is accepted.
      drive(1'b0, 1'b1, W_WORD, 1'b0, 32'h1001_1FFC, 32'h0BAD_F00D); #1;
      chk("edge_we", {31'h0, ram_we}, 32'h1);
      chk("edge_addr", {21'h0, ram_addr}, 32'h7FF);
      tick();
      drive_idle();
      chk("edge_mem", mem[2047], 32'h0BAD_F00D);

      // Reset during the RMW read cycle of a byte store.
      saved = mem[1];
      drive(1'b0, 1'b1, W_BYTE, 1'b0, 32'h1001_0004, 32'h0000_0055); #1;
`ifdef DMEM_BYTE_STROBE_EN
      chk("mid_pre_we", {31'h0, ram_we}, 32'h1);
`else
      chk("mid_pre_stall", {31'h0, dmem_stall}, 32'h1);
`endif
      rst = 1'b0; #1;
      chk("mid_ctl", {29'h0, ram_re, ram_we, dmem_stall}, 32'h0);
      chk("mid_ram_addr", {21'h0, ram_addr}, 32'h0);
      tick();
      drive_idle();
      tick();
      chk("mid_mem", mem[1], saved);
      chk("mid_rdata", dmem_rdata, 32'h0);
      chk("mid_faddr", fault_addr, 32'h0);
      chk("mid_fault", {31'h0, dmem_fault}, 32'h0);
      rst = 1'b1;
      tick();
      do_load("mid_ld", 32'h1001_0004, W_WORD, 1'b0, saved);

      // Load then store on consecutive accepted cycles.
      re0 = n_re;
      we0 = n_we;
      drive(1'b1, 1'b0, W_WORD, 1'b0, 32'h1001_0004, 32'h0); #1;
      chk("b2b_ld_stall", {31'h0, dmem_stall}, 32'h1);
      tick();
      chk("b2b_wait_ctl", {29'h0, ram_re, ram_we, dmem_stall}, 32'h0);
      tick();
      drive(1'b0, 1'b1, W_WORD, 1'b0, 32'h1001_0008, 32'h1122_3344); #1;
      chk("b2b_st_we", {31'h0, ram_we}, 32'h1);
      chk("b2b_st_addr", {21'h0, ram_addr}, 32'h2);
      chk("b2b_st_stall", {31'h0, dmem_stall}, 32'h0);
      chk("b2b_ld_data", dmem_rdata, 32'h1234_ABEF);
      tick();
      drive_idle();
      tick();
      chk("b2b_n_re", n_re - re0, 32'h1);
      chk("b2b_n_we", n_we - we0, 32'h1);
      chk("b2b_mem", mem[2], 32'h1122_3344);
      chk("b2b_mem1", mem[1], 32'h1234_ABEF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
